// File: rtl/reg_result_checker_if.sv
// Bundle of the checker's control, table-load, register-file and result signals.
// slave is the checker side; master is the bench/CPU-harness side.
interface reg_result_checker_if #(
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned ADDR_W     = 5,
    parameter int unsigned NUM_CHECKS = 16,
    parameter int unsigned CYC_W      = 16,
    parameter int unsigned IDX_W      = $clog2(NUM_CHECKS)
);
    logic              start;
    logic [CYC_W-1:0]  run_cycles;
    logic [IDX_W:0]    num_checks;
    logic              exp_we;
    logic [IDX_W-1:0]  exp_idx;
    logic [ADDR_W-1:0] exp_reg;
    logic [DATA_W-1:0] exp_val;
    logic [DATA_W-1:0] exp_mask;
    logic              cpu_run;
    logic [ADDR_W-1:0] rf_raddr;
    logic [DATA_W-1:0] rf_rdata;
    logic              busy;
    logic              done;
    logic              pass;
    logic [IDX_W:0]    err_count;
    logic [IDX_W-1:0]  fail_idx;
    logic [DATA_W-1:0] fail_got;

    modport slave (
        input  start, run_cycles, num_checks, exp_we, exp_idx, exp_reg, exp_val, exp_mask,
        input  rf_rdata,
        output cpu_run, rf_raddr, busy, done, pass, err_count, fail_idx, fail_got
    );

    modport master (
        output start, run_cycles, num_checks, exp_we, exp_idx, exp_reg, exp_val, exp_mask,
        output rf_rdata,
        input  cpu_run, rf_raddr, busy, done, pass, err_count, fail_idx, fail_got
    );
endinterface

// File: rtl/reg_result_checker.sv
// Run-and-check engine: gates the CPU for a programmed cycle count, then walks a table of
// expected {reg, val, mask} entries through a register-file read port and tallies mismatches.
module reg_result_checker #(
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned ADDR_W     = 5,
    parameter int unsigned NUM_CHECKS = 16,
    parameter int unsigned CYC_W      = 16,
    parameter int unsigned IDX_W      = $clog2(NUM_CHECKS)
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    reg_result_checker_if.slave  bus_io
);
    typedef enum logic [1:0] {StIdle, StRun, StCheck, StDone} state_e;

    localparam logic [IDX_W:0] ErrMax = '1;
    localparam logic [IDX_W:0] NumMax = (IDX_W+1)'(NUM_CHECKS);

    state_e            state_q, state_d;
    logic [CYC_W-1:0]  cnt_q, cnt_d;
    logic [IDX_W:0]    nchk_q, nchk_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [IDX_W:0]    err_q, err_d;
    logic [IDX_W-1:0]  fidx_q, fidx_d;
    logic [DATA_W-1:0] fgot_q, fgot_d;

    // Expected table; deliberately not reset so a reset between runs keeps the program.
    logic [ADDR_W-1:0] tbl_reg_q  [NUM_CHECKS];
    logic [DATA_W-1:0] tbl_val_q  [NUM_CHECKS];
    logic [DATA_W-1:0] tbl_mask_q [NUM_CHECKS];

    logic           idle_or_done;
    logic [31:0]    wr_idx;
    logic [IDX_W:0] nchk_in;
    logic           mismatch;
    logic           last_entry;

    assign idle_or_done = (state_q == StIdle) || (state_q == StDone);
    assign wr_idx       = 32'(bus_io.exp_idx);
    assign nchk_in      = (bus_io.num_checks > NumMax) ? NumMax : bus_io.num_checks;
    assign mismatch     = ((bus_io.rf_rdata ^ tbl_val_q[idx_q]) & tbl_mask_q[idx_q]) != '0;
    assign last_entry   = ((IDX_W+1)'(idx_q) + 1'b1) == nchk_q;

    always_ff @(posedge clk_i) begin
        if (bus_io.exp_we && idle_or_done && (wr_idx < NUM_CHECKS)) begin
            tbl_reg_q[bus_io.exp_idx]  <= bus_io.exp_reg;
            tbl_val_q[bus_io.exp_idx]  <= bus_io.exp_val;
            tbl_mask_q[bus_io.exp_idx] <= bus_io.exp_mask;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        nchk_d  = nchk_q;
        idx_d   = idx_q;
        err_d   = err_q;
        fidx_d  = fidx_q;
        fgot_d  = fgot_q;
        case (state_q)
            StIdle, StDone: begin
                if (bus_io.start) begin
                    cnt_d  = bus_io.run_cycles;
                    nchk_d = nchk_in;
                    idx_d  = '0;
                    err_d  = '0;
                    fidx_d = '0;
                    fgot_d = '0;
                    // An empty check list skips CHECK so done lands at run_cycles+1.
                    if (bus_io.run_cycles != '0) state_d = StRun;
                    else if (nchk_in == '0)      state_d = StDone;
                    else                         state_d = StCheck;
                end
            end
            StRun: begin
                cnt_d = cnt_q - 1'b1;
                if (cnt_q == CYC_W'(1)) begin
                    idx_d   = '0;
                    state_d = (nchk_q == '0) ? StDone : StCheck;
                end
            end
            StCheck: begin
                if (mismatch) begin
                    if (err_q != ErrMax) err_d = err_q + 1'b1;
                    if (err_q == '0) begin
                        fidx_d = idx_q;
                        fgot_d = bus_io.rf_rdata;
                    end
                end
                idx_d = idx_q + 1'b1;
                if (last_entry) state_d = StDone;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            nchk_q  <= '0;
            idx_q   <= '0;
            err_q   <= '0;
            fidx_q  <= '0;
            fgot_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            nchk_q  <= nchk_d;
            idx_q   <= idx_d;
            err_q   <= err_d;
            fidx_q  <= fidx_d;
            fgot_q  <= fgot_d;
        end
    end

    assign bus_io.cpu_run   = (state_q == StRun);
    assign bus_io.busy      = (state_q == StRun) || (state_q == StCheck);
    assign bus_io.done      = (state_q == StDone);
    assign bus_io.pass      = (state_q == StDone) && (err_q == '0);
    assign bus_io.err_count = err_q;
    assign bus_io.fail_idx  = fidx_q;
    assign bus_io.fail_got  = fgot_q;
    assign bus_io.rf_raddr  = (state_q == StCheck) ? tbl_reg_q[idx_q] : '0;
endmodule

// File: doc/reg_result_checker.md
# reg_result_checker

Parametrised run-and-check engine for the single-cycle processor's instruction test benches. It gates the CPU for a programmed number of cycles, then walks a table of expected register values through a register-file read port. It counts mismatches and latches the first failure. It replaces hand-written per-instruction assertion lists with a table-driven checker that supports any check count, data width and per-entry bit masks.

## Interface
Parameters:
- DATA_W, 32, register data width
- ADDR_W, 5, register-file address width
- NUM_CHECKS, 16, expected-table depth (power of two not required)
- CYC_W, 16, width of run-cycle counter
- IDX_W, $clog2(NUM_CHECKS), table index width (derived, not overridden)

Ports:
- clk  in  1  processor clock; all state changes on rising edge
- reset  in  1  asynchronous, active-high; one clock domain
- start  in  1  pulse; begins a run when idle
- run_cycles  in  CYC_W  CPU cycles to execute, sampled on start
- num_checks  in  IDX_W+1  table entries to check (0..NUM_CHECKS), sampled on start
- exp_we  in  1  table write strobe
- exp_idx  in  IDX_W  table write index
- exp_reg  in  ADDR_W  register number for the entry
- exp_val  in  DATA_W  expected value
- exp_mask  in  DATA_W  compare mask; 1 = bit checked
- cpu_run  out  1  CPU clock-enable / run permission
- rf_raddr  out  ADDR_W  register-file read address
- rf_rdata  in  DATA_W  register-file read data, combinational from rf_raddr
- busy  out  1  run or check in progress
- done  out  1  results valid; held until next accepted start
- pass  out  1  done and err_count == 0
- err_count  out  IDX_W+1  mismatching entries
- fail_idx  out  IDX_W  index of first mismatch
- fail_got  out  DATA_W  register value read at first mismatch

## Operation
- The table is a NUM_CHECKS-entry array of {reg, val, mask}. It is written when exp_we=1 and state is IDLE or DONE. Writes while busy are ignored. Writes to exp_idx >= NUM_CHECKS are ignored. Reset does not clear the table.
- FSM states: IDLE, RUN, CHECK, DONE.
  - IDLE/DONE + start: latch run_cycles and num_checks (num_checks clamped to NUM_CHECKS), clear err_count/fail_idx/fail_got/done. Go to RUN if run_cycles != 0, else CHECK.
  - RUN: cpu_run=1. A down-counter decrements each cycle and moves to CHECK after exactly run_cycles cycles of cpu_run high.
  - CHECK: index i starts at 0, rf_raddr = table[i].reg. Mismatch is ((rf_rdata ^ val) & mask) != 0. On mismatch err_count increments. If err_count was 0, fail_idx=i and fail_got=rf_rdata. i increments each cycle. After entry num_checks-1 the FSM goes to DONE. If num_checks=0, CHECK goes straight to DONE.
  - DONE: done=1, pass=(err_count==0).
- start in RUN or CHECK is ignored.
- err_count saturates at its maximum; it cannot wrap.

## Timing
- Reset values: cpu_run=0, busy=0, done=0, pass=0, err_count=0, fail_idx=0, fail_got=0, rf_raddr=0. State is IDLE.
- Edge 0 is the edge that samples start. cpu_run is high for cycles 1..run_cycles. busy rises at cycle 1.
- Check entry k is compared in cycle run_cycles+1+k. done and pass rise at cycle run_cycles+num_checks+1, and busy falls in the same cycle.
- Total latency from start to done is run_cycles + num_checks + 1 cycles.
- rf_raddr is registered-index driven and glitch-free within a cycle. It is 0 outside CHECK.
- Asserting reset mid-RUN or mid-CHECK drops cpu_run immediately (asynchronously) and returns the FSM to IDLE. Partial results are lost.

## Test plan
- Write 4 entries (s0=0xF0, s1=0x0F, s2=0xCC, s3=0xFFFFABCE, full masks). Run 9 cycles against a model holding those values. Required: done at cycle 14, pass=1, err_count=0, cpu_run high exactly 9 cycles.
- Same table with s2 holding 0xCD. Required: err_count=1, fail_idx=2, fail_got=0xCD, pass=0.
- Mask 0x0000FFFF on the s3 entry with expected 0x0000ABCE and register 0xFFFFABCE. Required: pass=1. With mask 0xFFFFFFFF: fail_idx=3.
- run_cycles=0, num_checks=0. Required: done one cycle after start, pass=1, cpu_run never high.
- Assert start again and exp_we (write to index 0) during RUN. Both must be ignored, with the table and timing unchanged. Then assert reset mid-CHECK: all outputs return to reset values asynchronously.
- Set all 16 entries mismatching. Required: err_count=16, fail_idx=0. Then set num_checks=20: it must be clamped to 16 with the same result.
